// File: rtl/mipi_pkg.sv
// Shared types and constants for the MIPI PHY phase calibration controller.
package mipi_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    typedef enum logic [3:0] {
        StIdle,
        StMrst,
        StWlock,
        StPsReq,
        StPsWait,
        StDwell,
        StEval,
        StMoveReq,
        StMoveWait,
        StFinish
    } state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/mipi_ps_port.sv
// MMCM dynamic phase-shift handshake: one-cycle psen, then wait for psdone or time out.
module mipi_ps_port #(
    parameter int unsigned PS_TIMEOUT = 1024
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic req_i,
    input  logic inc_i,
    input  logic psdone_i,
    output logic psen_o,
    output logic psincdec_o,
    output logic ack_o,
    output logic timeout_o
);

    localparam int unsigned TW = $clog2(PS_TIMEOUT + 1);

    logic          psen_d, psen_q;
    logic          inc_d, inc_q;
    logic          wait_d, wait_q;
    logic [TW-1:0] cnt_d, cnt_q;

    always_comb begin
        psen_d    = 1'b0;
        inc_d     = inc_q;
        wait_d    = wait_q;
        cnt_d     = cnt_q;
        ack_o     = 1'b0;
        timeout_o = 1'b0;
        if (wait_q) begin
            // psdone coincident with our own psen cannot belong to this request
            if (!psen_q && psdone_i) begin
                ack_o  = 1'b1;
                wait_d = 1'b0;
            end else if (cnt_q == TW'(PS_TIMEOUT - 1)) begin
                timeout_o = 1'b1;
                wait_d    = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (req_i) begin
            psen_d = 1'b1;
            inc_d  = inc_i;
            wait_d = 1'b1;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            psen_q <= 1'b0;
            inc_q  <= 1'b0;
            wait_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            psen_q <= psen_d;
            inc_q  <= inc_d;
            wait_q <= wait_d;
            cnt_q  <= cnt_d;
        end
    end

    assign psen_o     = psen_q;
    assign psincdec_o = inc_q;

endmodule

// File: rtl/mipi_phase_cal.sv
// Sweeps the MMCM sampling phase, scores each step on sync/error counts and parks the
// phase at the centre of the longest contiguous good window.
module mipi_phase_cal
    import mipi_pkg::*;
#(
    parameter int unsigned STEPS      = 56,
    parameter int unsigned DWELL      = 4096,
    parameter int unsigned MIN_SYNC   = 4,
    parameter int unsigned RST_CYCLES = 16,
    parameter int unsigned PS_TIMEOUT = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         locked,
    input  logic                         sync_ok,
    input  logic                         err,
    output logic                         mmcm_reset,
    output logic                         psen,
    output logic                         psincdec,
    input  logic                         psdone,
    output logic                         busy,
    output logic                         done,
    output logic                         fail,
    output logic [$clog2(STEPS)-1:0]     best_start,
    output logic [$clog2(STEPS+1)-1:0]   best_len,
    output logic [$clog2(STEPS+1)-1:0]   phase_pos
);

    localparam int unsigned SW = $clog2(STEPS);
    localparam int unsigned LW = $clog2(STEPS + 1);
    localparam int unsigned TW = $clog2(max3(DWELL, PS_TIMEOUT, RST_CYCLES) + 1);

    state_e        state_d, state_q;
    logic [TW-1:0] tmr_d, tmr_q;
    logic [7:0]    sync_cnt_d, sync_cnt_q;
    logic [7:0]    err_cnt_d, err_cnt_q;
    logic [SW-1:0] run_start_d, run_start_q;
    logic [LW-1:0] run_len_d, run_len_q;
    logic [SW-1:0] best_start_d, best_start_q;
    logic [LW-1:0] best_len_d, best_len_q;
    logic [LW-1:0] phase_pos_d, phase_pos_q;
    logic          fail_d, fail_q;

    logic          ps_req, ps_inc, ps_ack, ps_timeout;
    logic          good;
    logic [LW-1:0] target;

    mipi_ps_port #(
        .PS_TIMEOUT(PS_TIMEOUT)
    ) u_ps_port (
        .clk_i      (clk),
        .reset_i    (reset),
        .req_i      (ps_req),
        .inc_i      (ps_inc),
        .psdone_i   (psdone),
        .psen_o     (psen),
        .psincdec_o (psincdec),
        .ack_o      (ps_ack),
        .timeout_o  (ps_timeout)
    );

    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        sync_cnt_d   = sync_cnt_q;
        err_cnt_d    = err_cnt_q;
        run_start_d  = run_start_q;
        run_len_d    = run_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        phase_pos_d  = phase_pos_q;
        fail_d       = fail_q;
        ps_req       = 1'b0;
        ps_inc       = 1'b0;
        good         = 1'b0;
        target       = '0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d      = StMrst;
                    tmr_d        = '0;
                    fail_d       = 1'b0;
                    best_start_d = '0;
                    best_len_d   = '0;
                    phase_pos_d  = '0;
                    run_start_d  = '0;
                    run_len_d    = '0;
                end
            end
            StMrst: begin
                phase_pos_d = '0;
                if (tmr_q == TW'(RST_CYCLES - 1)) begin
                    tmr_d   = '0;
                    state_d = StWlock;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            StWlock: begin
                if (locked) begin
                    state_d    = StDwell;
                    tmr_d      = '0;
                    sync_cnt_d = '0;
                    err_cnt_d  = '0;
                end else if (tmr_q == TW'(PS_TIMEOUT - 1)) begin
                    fail_d  = 1'b1;
                    state_d = StFinish;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            StDwell: begin
                if (!locked) begin
                    fail_d  = 1'b1;
                    state_d = StFinish;
                end else begin
                    if (sync_ok && (sync_cnt_q != 8'hFF)) sync_cnt_d = sync_cnt_q + 1'b1;
                    if (err && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 1'b1;
                    if (tmr_q == TW'(DWELL - 1)) begin
                        state_d = StEval;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
            end
            StEval: begin
                good = (32'(sync_cnt_q) >= MIN_SYNC) && (err_cnt_q == 8'd0);
                if (good) begin
                    if (run_len_q == '0) run_start_d = SW'(phase_pos_q);
                    run_len_d = run_len_q + 1'b1;
                    // strict compare keeps the earliest window on ties
                    if (run_len_d > best_len_q) begin
                        best_len_d   = run_len_d;
                        best_start_d = run_start_d;
                    end
                end else begin
                    run_len_d = '0;
                end
                if (phase_pos_q < LW'(STEPS - 1)) begin
                    state_d = StPsReq;
                end else begin
                    state_d = StMoveReq;
                end
            end
            StPsReq: begin
                ps_req  = 1'b1;
                ps_inc  = 1'b1;
                state_d = StPsWait;
            end
            StPsWait: begin
                if (ps_ack) begin
                    phase_pos_d = phase_pos_q + 1'b1;
                    state_d     = StDwell;
                    tmr_d       = '0;
                    sync_cnt_d  = '0;
                    err_cnt_d   = '0;
                end else if (ps_timeout) begin
                    fail_d  = 1'b1;
                    state_d = StFinish;
                end
            end
            StMoveReq: begin
                if (best_len_q == '0) begin
                    fail_d = 1'b1;
                end else begin
                    target = LW'(best_start_q) + (best_len_q >> 1);
                end
                if (phase_pos_q == target) begin
                    state_d = StFinish;
                end else begin
                    ps_req  = 1'b1;
                    state_d = StMoveWait;
                end
            end
            StMoveWait: begin
                if (ps_ack) begin
                    phase_pos_d = phase_pos_q - 1'b1;
                    state_d     = StMoveReq;
                end else if (ps_timeout) begin
                    fail_d  = 1'b1;
                    state_d = StFinish;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            tmr_q        <= '0;
            sync_cnt_q   <= '0;
            err_cnt_q    <= '0;
            run_start_q  <= '0;
            run_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
            phase_pos_q  <= '0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            sync_cnt_q   <= sync_cnt_d;
            err_cnt_q    <= err_cnt_d;
            run_start_q  <= run_start_d;
            run_len_q    <= run_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
            phase_pos_q  <= phase_pos_d;
            fail_q       <= fail_d;
        end
    end

    assign mmcm_reset = (state_q == StMrst);
    assign busy       = (state_q != StIdle) && (state_q != StFinish);
    assign done       = (state_q == StFinish);
    assign fail       = fail_q;
    assign best_start = best_start_q;
    assign best_len   = best_len_q;
    assign phase_pos  = phase_pos_q;

endmodule

// File: tb/tb_mipi_phase_cal.sv
// Scoreboard bench for mipi_phase_cal with a behavioural MMCM/PHY responder.
module tb_mipi_phase_cal;

    localparam int unsigned STEPS      = 16;
    localparam int unsigned DWELL      = 64;
    localparam int unsigned MIN_SYNC   = 4;
    localparam int unsigned RST_CYCLES = 16;
    localparam int unsigned PS_TIMEOUT = 1024;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       locked = 1'b0;
    logic       sync_ok = 1'b0;
    logic       err = 1'b0;
    logic       psdone = 1'b0;
    logic       mmcm_reset, psen, psincdec, busy, done, fail;
    logic [3:0] best_start;
    logic [4:0] best_len;
    logic [4:0] phase_pos;

    typedef struct {
        logic fail;
        int   bs;
        int   bl;
        int   pp;
        int   n_inc;
        int   n_dec;
    } exp_t;

    exp_t run_q[$];
    int   rst_q[$];
    int   mode[16];
    int   withhold_phase = -1;
    logic lock_en = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mipi_phase_cal #(
        .STEPS      (STEPS),
        .DWELL      (DWELL),
        .MIN_SYNC   (MIN_SYNC),
        .RST_CYCLES (RST_CYCLES),
        .PS_TIMEOUT (PS_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .locked     (locked),
        .sync_ok    (sync_ok),
        .err        (err),
        .mmcm_reset (mmcm_reset),
        .psen       (psen),
        .psincdec   (psincdec),
        .psdone     (psdone),
        .busy       (busy),
        .done       (done),
        .fail       (fail),
        .best_start (best_start),
        .best_len   (best_len),
        .phase_pos  (phase_pos)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // MMCM/PHY responder: psdone 3 cycles after psen, lock after reset, per-step link quality.
    // mode: 1 = good (8 syncs per dwell), 2 = weak (<=3 syncs), other = syncs plus errors.
    initial begin : phy_model
        int mphase;
        int pend;
        int cyc;
        int lock_delay;
        mphase = 0;
        pend = 0;
        cyc = 0;
        lock_delay = 5;
        forever begin
            @(negedge clk);
            cyc++;
            psdone  = 1'b0;
            sync_ok = 1'b0;
            err     = 1'b0;
            if (reset || mmcm_reset) begin
                mphase = 0;
                pend = 0;
                lock_delay = 5;
            end else begin
                if (psen) begin
                    mphase += psincdec ? 1 : -1;
                    pend = 3;
                end else if (pend > 0) begin
                    pend--;
                    if (pend == 0 && mphase != withhold_phase) psdone = 1'b1;
                end
                if (lock_delay > 0) lock_delay--;
                if (busy && mphase >= 0 && mphase < 16) begin
                    case (mode[mphase])
                        1: sync_ok = (cyc % 8 == 0);
                        2: sync_ok = (cyc % 24 == 0);
                        default: begin
                            sync_ok = (cyc % 8 == 0);
                            err     = (cyc % 16 == 0);
                        end
                    endcase
                end
            end
            locked = lock_en && (lock_delay == 0) && !mmcm_reset;
        end
    end

    initial begin : monitor
        exp_t e;
        int   n_inc;
        int   n_dec;
        int   wd;
        logic pend_mon;
        n_inc = 0;
        n_dec = 0;
        wd = 0;
        pend_mon = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                if (rst_q.size() > 0) begin
                    void'(rst_q.pop_front());
                    chk("reset_outputs", {12'd0, mmcm_reset, psen, psincdec, busy, done, fail,
                                          best_start, best_len, phase_pos}, 32'd0);
                end
                n_inc = 0;
                n_dec = 0;
                wd = 0;
                pend_mon = 1'b0;
            end else begin
                if (psen) begin
                    chk("psen_before_psdone", {31'd0, pend_mon}, 32'd0);
                    pend_mon = 1'b1;
                    if (psincdec) n_inc++;
                    else n_dec++;
                end
                if (psdone) pend_mon = 1'b0;
                if (done) begin
                    if (run_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done=1 expected no completion");
                    end else begin
                        e = run_q.pop_front();
                        chk("fail", {31'd0, fail}, {31'd0, e.fail});
                        chk("best_start", {28'd0, best_start}, e.bs);
                        chk("best_len", {27'd0, best_len}, e.bl);
                        chk("phase_pos", {27'd0, phase_pos}, e.pp);
                        chk("inc_pulses", n_inc, e.n_inc);
                        chk("dec_pulses", n_dec, e.n_dec);
                        chk("busy_at_done", {31'd0, busy}, 32'd0);
                    end
                    n_inc = 0;
                    n_dec = 0;
                    wd = 0;
                    pend_mon = 1'b0;
                end else if (run_q.size() > 0) begin
                    wd++;
                    if (wd > 12000) begin
                        checks++;
                        errors++;
                        $display("FAIL done_timeout: got no done in %0d cycles expected done", wd);
                        void'(run_q.pop_front());
                        wd = 0;
                    end
                end
            end
        end
    end

    task automatic set_mode(input int lo, input int hi, input int m);
        for (int i = lo; i <= hi; i++) mode[i] = m;
    endtask

    task automatic issue(input logic f, input int bs, input int bl, input int pp,
                         input int ni, input int nd);
        exp_t e;
        e.fail = f;
        e.bs = bs;
        e.bl = bl;
        e.pp = pp;
        e.n_inc = ni;
        e.n_dec = nd;
        run_q.push_back(e);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 15000 && run_q.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    task automatic run(input logic f, input int bs, input int bl, input int pp,
                       input int ni, input int nd);
        issue(f, bs, bl, pp, ni, nd);
        wait_empty();
    endtask

    initial begin : stim
        rst_q.push_back(1);
        set_mode(0, 15, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);

        // single window 5..10, weak and erroring steps around it
        set_mode(0, 4, 2);
        set_mode(5, 10, 1);
        set_mode(11, 15, 0);
        run(1'b0, 5, 6, 8, 15, 7);

        // two equal windows: earliest wins
        set_mode(0, 15, 0);
        set_mode(1, 3, 1);
        set_mode(9, 11, 1);
        run(1'b0, 1, 3, 2, 15, 13);

        // no good step
        set_mode(0, 15, 0);
        run(1'b1, 0, 0, 0, 15, 15);

        // psdone withheld on the step 4 -> 5 increment
        withhold_phase = 5;
        run(1'b1, 0, 0, 4, 5, 0);
        withhold_phase = -1;

        // lock lost during step 7 dwell; a start while busy must be ignored
        set_mode(0, 15, 0);
        set_mode(2, 3, 1);
        issue(1'b1, 2, 2, 7, 7, 0);
        for (int i = 0; i < 3000 && phase_pos != 5'd7; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        lock_en = 1'b0;
        wait_empty();
        lock_en = 1'b1;
        repeat (4) @(negedge clk);

        // reset during the move phase
        set_mode(0, 4, 2);
        set_mode(5, 10, 1);
        set_mode(11, 15, 0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5000 && !(psen && !psincdec); i++) @(negedge clk);
        rst_q.push_back(1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);

        // good at step 0 and the last step: no wrap, two runs of length 1
        set_mode(0, 15, 2);
        set_mode(0, 0, 1);
        set_mode(15, 15, 1);
        run(1'b0, 0, 1, 0, 15, 15);

        repeat (10) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mipi_phase_cal.md
# mipi_phase_cal

Calibration controller for the Artix MIPI PHY deserializer. Drives the MMCM reset and dynamic phase-shift port (psen/psincdec/psdone) and sweeps the sampling phase in fine steps. At each step it counts sync-pattern detections and error pulses reported by the PHY/packet layer, then parks the MMCM at the centre of the longest contiguous good window. Sits beside the deserializer in the psclk domain and is started by firmware after link bring-up.

## Interface
- STEPS, 56: phase steps swept (56 = one VCO period)
- DWELL, 4096: clk cycles observed per step
- MIN_SYNC, 4: minimum sync detections for a step to be good
- RST_CYCLES, 16: mmcm_reset assertion length
- PS_TIMEOUT, 1024: max cycles waiting for psdone or locked
- clk  in  1  calibration clock, also drives the MMCM PSCLK
- reset  in  1  synchronous, active-high
- start  in  1  pulse: begin calibration; ignored while busy
- locked  in  1  MMCM locked, already synchronized to clk
- sync_ok  in  1  one-cycle pulse per sync-pattern (0xB8) detection, synchronized to clk
- err  in  1  one-cycle pulse per ECC/CRC error, synchronized to clk
- mmcm_reset  out  1  MMCM reset
- psen  out  1  one-cycle phase-shift request
- psincdec  out  1  1 = increment, 0 = decrement; valid with psen
- psdone  in  1  MMCM phase-shift acknowledge
- busy  out  1  calibration in progress
- done  out  1  one-cycle pulse at completion (pass or fail)
- fail  out  1  last run found no good step, or hit a timeout/lock loss; held until next start
- best_start  out  $clog2(STEPS)  first step of the chosen window
- best_len  out  $clog2(STEPS+1)  chosen window length
- phase_pos  out  $clog2(STEPS+1)  current phase offset in steps from MMCM reset

## Operation
- States: IDLE, MRST, WLOCK, PS_REQ, PS_WAIT, DWELL, EVAL, MOVE_REQ, MOVE_WAIT, FINISH.
- IDLE: on start, clear fail, best_*, phase_pos, run tracker; go to MRST.
- MRST: mmcm_reset=1 for RST_CYCLES cycles, then WLOCK. MMCM reset zeroes the phase, so phase_pos=0.
- WLOCK: wait for locked. Timeout -> fail, FINISH.
- DWELL: count sync_ok (saturating 8-bit) and err (saturating 8-bit) for DWELL cycles. locked falling -> fail, FINISH.
- EVAL: good = (sync_cnt >= MIN_SYNC) && (err_cnt == 0).
  - If good, extend the current run; if the current run is strictly longer than best_len, update best_start and best_len. Earliest run wins ties.
  - If not good, reset the current run.
  - If step index < STEPS-1: go to PS_REQ with psincdec=1.
  - Otherwise go to MOVE_REQ.
- PS_REQ/PS_WAIT: pulse psen, wait psdone, phase_pos ±1, then return to the caller (DWELL or MOVE).
- MOVE: target = best_start + best_len/2 (floor), or 0 if best_len==0 (fail=1). Issue decrements until phase_pos == target, then FINISH.
- FINISH: done=1 for one cycle, go to IDLE.
- Runs do not wrap from step STEPS-1 to step 0.

## Timing
- Reset values: mmcm_reset=0, psen=0, psincdec=0, busy=0, done=0, fail=0, best_start=0, best_len=0, phase_pos=0; state IDLE.
- busy rises the cycle after start is sampled and falls in the same cycle done pulses.
- psen is exactly one cycle wide. A new psen is never issued before psdone for the previous one.
- psdone arriving in the same cycle as psen is not valid; psdone is only accepted in PS_WAIT/MOVE_WAIT.
- psdone timeout (PS_TIMEOUT cycles) -> fail, FINISH. phase_pos is left at its last acknowledged value.
- sync_ok and err in the same cycle are both counted. The counters clear on DWELL entry, and the first counted cycle is the DWELL entry cycle.
- Reset mid-run: everything returns to reset values at the next edge and psen is dropped. The true MMCM phase is unknown until the next run, whose MRST restores it.
- The sweep always starts from phase 0 (step 0 is observed before any increment): STEPS dwells and STEPS-1 increments.

## Structure
- Shared package mipi_pkg: state enum and the SYNC_BYTE=8'hB8 constant.
- Sub-module mipi_ps_port: psen/psdone handshake with timeout, reused for both sweep and move; outputs ack/timeout pulses.

## Test plan
- STEPS=16, DWELL=64, MIN_SYNC=4. Model gives ≥4 sync_ok on steps 5–10 only -> best_start=5, best_len=6, final phase_pos=8, fail=0, exactly 15 inc + 7 dec psen pulses.
- Two good runs, steps 1–3 and 9–11 -> earliest wins: best_start=1, best_len=3, phase_pos=2.
- No good step (all err) -> fail=1, best_len=0, phase_pos returns to 0, done pulses once.
- psdone withheld at step 4 -> timeout after 1024 cycles, fail=1, phase_pos=4, busy=0.
- locked drops during step 7 dwell -> fail=1, FINISH; start during busy is ignored; reset mid-MOVE -> all outputs at reset values next cycle.
- Good step at the final index 15 with good step 0 -> no wrap: runs treated separately, both have length 1, best_start=0.
